cache_mem_ctrl: RTL and testbench
=================================

Name: cache_mem_ctrl

Overview:
- Memory-side responder for the cache request interface: accepts instruction reads from the icache and data reads/writes from the dcache.
- Arbitrates between them and drives a single-port RAM.
- Returns per-requester wait/load responses: iwait/iload, dwait/dload.
- Sits between the cache pair and the RAM model.
- One transaction in flight at a time. Dcache has priority, with a starvation guard for the icache.

Parameters:
- STARVE_MAX, 8: consecutive cycles an icache request may be passed over before it is forced to win arbitration.
- TIMEOUT_MAX, 64: cycles a granted transaction may stay outside ACCESS before it is aborted and flagged.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  low for exactly the cycle iload is valid.
- iload  out  32  instruction data.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32  dcache address.
- dstore  in  32  write data.
- dwait  out  1  low for exactly the completing cycle.
- dload  out  32  read data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
- mem_err  out  1  sticky error flag.

Behaviour:
- Reset: nRST is an asynchronous, active-low reset; the clock is CLK. On reset:
  - state = IDLE;
  - iwait = 1, dwait = 1, iload = 0, dload = 0;
  - ramREN = 0, ramWEN = 0, ramaddr = 0, ramstore = 0;
  - mem_err = 0; starve and timeout counters = 0.
- FSM states: IDLE, DSERV, ISERV.
- IDLE:
  - RAM enables are 0; waits are 1.
  - Arbitration, registered at the clock edge:
    - If (dREN|dWEN) and starve_cnt < STARVE_MAX, go to DSERV.
    - Otherwise, if iREN, go to ISERV.
- DSERV:
  - Combinationally: ramaddr = daddr, ramstore = dstore, ramWEN = dWEN, ramREN = dREN & ~dWEN. Write wins if both are set.
  - When ramstate == ACCESS: dwait = 0 and dload = ramload in the same cycle; next state is IDLE.
- ISERV:
  - Combinationally: ramaddr = iaddr, ramREN = 1, ramWEN = 0.
  - When ramstate == ACCESS: iwait = 0 and iload = ramload; next state is IDLE.
- Latency:
  - Arbitration costs 1 cycle. With a zero-wait RAM, the response arrives in the cycle after the request is first seen.
  - IDLE is visited for 1 bubble cycle between back-to-back transactions.
- Request withdrawn mid-service: if the granted requester's enable(s) drop, the next state is IDLE. RAM enables drop that cycle and no wait-low pulse is issued.
- Response outputs: iload and dload are 0 in every cycle whose wait is 1.
- Starvation guard (starve_cnt, saturating at STARVE_MAX):
  - Increments each cycle iREN = 1 and state != ISERV.
  - Clears on entry to ISERV or when iREN = 0.
- Timeout (tmo_cnt):
  - Counts cycles in DSERV/ISERV with ramstate != ACCESS; clears on state change.
  - At TIMEOUT_MAX: mem_err is set, the next state is IDLE, and no wait-low pulse is issued.
- ramstate == ERROR while serving: mem_err is set, the next state is IDLE, and the wait stays 1.
- mem_err is sticky until nRST.
- Reset asserted mid-transaction: everything returns to reset values immediately (asynchronously); the in-flight transaction is dropped.
- Address rule: addresses pass through unmodified. The low two bits are not checked.

Optional Feature:
- Macro: CACHE_MEM_CTRL_STATS_EN.
- With the macro defined:
  - Adds outputs iacc_cnt[31:0] and dacc_cnt[31:0].
  - Each counter increments on every completed (wait-low) transaction of its requester and wraps at 2^32.
  - Both are reset to 0.
- Without the macro: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cpu_types_pkg:
  - ramstate_t enum (FREE = 0, BUSY = 1, ACCESS = 2, ERROR = 3);
  - word_t;
  - memctrl_state_t (IDLE, DSERV, ISERV).
- One natural sub-module: mem_arb_guard, holding the starve and timeout counters and producing force_i and tmo_hit.

Test Plan:
- Icache read only: iREN = 1, iaddr = 0x40, RAM answers ACCESS after 2 BUSY cycles with 0xDEADBEEF -> iwait low exactly 1 cycle, in the 4th cycle after the request; iload = 0xDEADBEEF that cycle.
- Simultaneous requests: iREN = 1 and dREN = 1, zero-wait RAM -> dcache served first (dwait low at cycle 1); icache served at cycle 3; ramaddr follows each grant.
- Starvation: dWEN held continuously and iREN = 1, STARVE_MAX = 8 -> an ISERV grant occurs no later than the 9th cycle of icache waiting.
- Timeout: ramstate stuck at BUSY, TIMEOUT_MAX = 64 -> mem_err rises after 64 cycles in DSERV; dwait never goes low; FSM is back in IDLE.
- Withdrawal and reset: dREN dropped mid-DSERV -> ramREN = 0 that cycle, no dwait pulse. nRST pulsed mid-ISERV -> all outputs return to reset values asynchronously.
- Stats (macro defined): 3 icache and 5 dcache completions -> iacc_cnt = 3, dacc_cnt = 5.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/memory side: RAM handshake state,
// data word and the memory controller FSM encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DSERV = 2'd1,
        ISERV = 2'd2
    } memctrl_state_t;

    localparam int unsigned STARVE_MAX_DEF  = 8;
    localparam int unsigned TIMEOUT_MAX_DEF = 64;

    function automatic logic is_serving(memctrl_state_t s);
        return s != IDLE;
    endfunction

endpackage

// File: rtl/mem_arb_guard.sv
// Starvation and timeout counters for cache_mem_ctrl.
// Ports: CLK, nRST, iREN, state, next_state, ramstate in; force_i, tmo_hit out.
module mem_arb_guard
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_MAX  = STARVE_MAX_DEF,
    parameter int unsigned TIMEOUT_MAX = TIMEOUT_MAX_DEF
) (
    input  logic           CLK,
    input  logic           nRST,
    input  logic           iREN,
    input  memctrl_state_t state,
    input  memctrl_state_t next_state,
    input  ramstate_t      ramstate,
    output logic           force_i,
    output logic           tmo_hit
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT_MAX + 1);

    logic [SW-1:0] r_starve;
    logic [TW-1:0] r_tmo;
    logic          w_stall;
    logic          w_i_entry;

    assign w_stall   = is_serving(state) && (ramstate != ACCESS);
    assign w_i_entry = (next_state == ISERV) && (state != ISERV);
    assign force_i   = iREN && (r_starve >= SW'(STARVE_MAX));
    // Fires on the last stalled cycle so the abort lands on the
    // TIMEOUT_MAX-th edge spent waiting.
    assign tmo_hit   = w_stall && (r_tmo == TW'(TIMEOUT_MAX - 1));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_starve <= '0;
        end else if (!iREN || w_i_entry) begin
            r_starve <= '0;
        end else if (state != ISERV && r_starve < SW'(STARVE_MAX)) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_tmo <= '0;
        end else if (next_state != state) begin
            r_tmo <= '0;
        end else if (w_stall) begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

endmodule

// File: rtl/cache_mem_ctrl.sv
// Memory-side arbiter between icache and dcache driving one RAM port.
// Ports: cache req/resp (iREN/iaddr/iwait/iload, dREN/dWEN/daddr/dstore/
// dwait/dload), RAM (ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate),
// sticky mem_err; iacc_cnt/dacc_cnt with CACHE_MEM_CTRL_STATS_EN.
module cache_mem_ctrl
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_MAX  = STARVE_MAX_DEF,
    parameter int unsigned TIMEOUT_MAX = TIMEOUT_MAX_DEF
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      mem_err
`ifdef CACHE_MEM_CTRL_STATS_EN
    ,
    output word_t     iacc_cnt,
    output word_t     dacc_cnt
`endif
);

    memctrl_state_t r_state;
    memctrl_state_t w_next;
    logic           r_mem_err;
    logic           w_err_set;
    logic           w_dreq;
    logic           w_force_i;
    logic           w_tmo_hit;
    logic           w_idone;
    logic           w_ddone;

    assign w_dreq  = dREN | dWEN;
    assign mem_err = r_mem_err;

    mem_arb_guard #(
        .STARVE_MAX  (STARVE_MAX),
        .TIMEOUT_MAX (TIMEOUT_MAX)
    ) u_guard (
        .CLK        (CLK),
        .nRST       (nRST),
        .iREN       (iREN),
        .state      (r_state),
        .next_state (w_next),
        .ramstate   (ramstate),
        .force_i    (w_force_i),
        .tmo_hit    (w_tmo_hit)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state   <= IDLE;
            r_mem_err <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_mem_err <= r_mem_err | w_err_set;
        end
    end

    // A withdrawn request is checked first so it never completes,
    // even if the RAM reports ACCESS in the same cycle.
    always_comb begin
        w_next    = r_state;
        iwait     = 1'b1;
        dwait     = 1'b1;
        iload     = '0;
        dload     = '0;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;
        w_err_set = 1'b0;
        w_idone   = 1'b0;
        w_ddone   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_dreq && !w_force_i) begin
                    w_next = DSERV;
                end else if (iREN) begin
                    w_next = ISERV;
                end
            end
            DSERV: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (!w_dreq) begin
                    w_next = IDLE;
                end else if (ramstate == ERROR) begin
                    w_err_set = 1'b1;
                    w_next    = IDLE;
                end else if (ramstate == ACCESS) begin
                    dwait   = 1'b0;
                    dload   = ramload;
                    w_ddone = 1'b1;
                    w_next  = IDLE;
                end else if (w_tmo_hit) begin
                    w_err_set = 1'b1;
                    w_next    = IDLE;
                end
            end
            ISERV: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                if (!iREN) begin
                    w_next = IDLE;
                end else if (ramstate == ERROR) begin
                    w_err_set = 1'b1;
                    w_next    = IDLE;
                end else if (ramstate == ACCESS) begin
                    iwait   = 1'b0;
                    iload   = ramload;
                    w_idone = 1'b1;
                    w_next  = IDLE;
                end else if (w_tmo_hit) begin
                    w_err_set = 1'b1;
                    w_next    = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

`ifdef CACHE_MEM_CTRL_STATS_EN
    word_t r_iacc;
    word_t r_dacc;

    assign iacc_cnt = r_iacc;
    assign dacc_cnt = r_dacc;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_iacc <= '0;
            r_dacc <= '0;
        end else begin
            if (w_idone) r_iacc <= r_iacc + 32'd1;
            if (w_ddone) r_dacc <= r_dacc + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Directed cycle-trace bench for cache_mem_ctrl: vector table plus
// sequences for starvation, timeout and asynchronous reset.
module tb_cache_mem_ctrl;
    import cpu_types_pkg::*;

    typedef struct {
        logic [2:0] req;
        word_t      iaddr;
        word_t      daddr;
        word_t      dstore;
        ramstate_t  rs;
        word_t      rload;
        logic [4:0] flg;
        word_t      eil;
        word_t      edl;
        word_t      ea;
        word_t      es;
    } vec_t;

    logic      CLK;
    logic      nRST;
    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      mem_err;
`ifdef CACHE_MEM_CTRL_STATS_EN
    word_t     iacc_cnt;
    word_t     dacc_cnt;
`endif

    int n_run;
    int n_fail;

    logic [132:0] w_outs;
    assign w_outs = {iwait, dwait, ramREN, ramWEN, mem_err,
                     iload, dload, ramaddr, ramstore};

    localparam logic [132:0] RST_EXP = {5'b11000, 128'd0};

    cache_mem_ctrl dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .mem_err  (mem_err)
`ifdef CACHE_MEM_CTRL_STATS_EN
        ,
        .iacc_cnt (iacc_cnt),
        .dacc_cnt (dacc_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(logic [2:0] req, word_t ia, word_t da,
                                word_t ds, ramstate_t rs, word_t rl,
                                logic [4:0] f, word_t eil, word_t edl,
                                word_t ea, word_t es);
        vec_t v;
        v.req = req; v.iaddr = ia; v.daddr = da; v.dstore = ds;
        v.rs = rs; v.rload = rl; v.flg = f; v.eil = eil;
        v.edl = edl; v.ea = ea; v.es = es;
        return v;
    endfunction

    task automatic chk_vec(string nm, logic [132:0] act, logic [132:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_w(string nm, word_t act, word_t exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(logic [2:0] req, word_t ia, word_t da,
                         word_t ds, ramstate_t rs, word_t rl);
        {iREN, dREN, dWEN} = req;
        iaddr = ia; daddr = da; dstore = ds;
        ramstate = rs; ramload = rl;
    endtask

    task automatic idle_in();
        drive(3'b000, '0, '0, '0, FREE, '0);
    endtask

    task automatic do_reset();
        idle_in();
        nRST = 1'b0;
        #2;
        nRST = 1'b1;
    endtask

    vec_t tv[$];
    int   first_i;
    int   dcnt;
    int   dlow;

    initial begin
        n_run  = 0;
        n_fail = 0;
        nRST   = 1'b0;
        idle_in();
        #2;
        chk_vec("reset_state", w_outs, RST_EXP);
        @(posedge CLK);
        #1;
        nRST = 1'b1;

        // req = {iREN, dREN, dWEN}; flg = {iwait, dwait, REN, WEN, err}
        tv.push_back(mk(3'b100, 32'h40, '0, '0, FREE, '0, 5'b11000, '0, '0, '0, '0));
        tv.push_back(mk(3'b100, 32'h40, '0, '0, BUSY, 32'hDEADBEEF, 5'b11100, '0, '0, 32'h40, '0));
        tv.push_back(mk(3'b100, 32'h40, '0, '0, BUSY, 32'hDEADBEEF, 5'b11100, '0, '0, 32'h40, '0));
        tv.push_back(mk(3'b100, 32'h40, '0, '0, ACCESS, 32'hDEADBEEF, 5'b01100, 32'hDEADBEEF, '0, 32'h40, '0));
        tv.push_back(mk(3'b000, '0, '0, '0, FREE, '0, 5'b11000, '0, '0, '0, '0));
        tv.push_back(mk(3'b110, 32'h200, 32'h100, '0, ACCESS, 32'hAAAA0001, 5'b11000, '0, '0, '0, '0));
        tv.push_back(mk(3'b110, 32'h200, 32'h100, '0, ACCESS, 32'hAAAA0002, 5'b10100, '0, 32'hAAAA0002, 32'h100, '0));
        tv.push_back(mk(3'b100, 32'h200, 32'h100, '0, ACCESS, 32'hAAAA0003, 5'b11000, '0, '0, '0, '0));
        tv.push_back(mk(3'b100, 32'h200, 32'h100, '0, ACCESS, 32'hBBBB0004, 5'b01100, 32'hBBBB0004, '0, 32'h200, '0));
        tv.push_back(mk(3'b000, '0, '0, '0, FREE, '0, 5'b11000, '0, '0, '0, '0));
        tv.push_back(mk(3'b011, '0, 32'h300, 32'hCAFEF00D, FREE, '0, 5'b11000, '0, '0, '0, '0));
        tv.push_back(mk(3'b011, '0, 32'h300, 32'hCAFEF00D, BUSY, '0, 5'b11010, '0, '0, 32'h300, 32'hCAFEF00D));
        tv.push_back(mk(3'b011, '0, 32'h300, 32'hCAFEF00D, ACCESS, 32'h12345678, 5'b10010, '0, 32'h12345678, 32'h300, 32'hCAFEF00D));
        tv.push_back(mk(3'b000, '0, '0, '0, FREE, '0, 5'b11000, '0, '0, '0, '0));
        tv.push_back(mk(3'b010, '0, 32'h44, '0, FREE, '0, 5'b11000, '0, '0, '0, '0));
        tv.push_back(mk(3'b010, '0, 32'h44, '0, BUSY, '0, 5'b11100, '0, '0, 32'h44, '0));
        tv.push_back(mk(3'b000, '0, 32'h44, '0, ACCESS, 32'h55, 5'b11000, '0, '0, 32'h44, '0));
        tv.push_back(mk(3'b010, '0, 32'h44, '0, ACCESS, 32'h66, 5'b11000, '0, '0, '0, '0));
        tv.push_back(mk(3'b010, '0, 32'h44, '0, ACCESS, 32'h77, 5'b10100, '0, 32'h77, 32'h44, '0));
        tv.push_back(mk(3'b010, '0, 32'h48, '0, ACCESS, 32'h78, 5'b11000, '0, '0, '0, '0));
        tv.push_back(mk(3'b010, '0, 32'h4C, '0, ACCESS, 32'h79, 5'b10100, '0, 32'h79, 32'h4C, '0));
        tv.push_back(mk(3'b010, '0, 32'h50, '0, ACCESS, 32'h7A, 5'b11000, '0, '0, '0, '0));
        tv.push_back(mk(3'b010, '0, 32'h51, '0, ACCESS, 32'h7B, 5'b10100, '0, 32'h7B, 32'h51, '0));
        tv.push_back(mk(3'b000, '0, '0, '0, FREE, '0, 5'b11000, '0, '0, '0, '0));
        tv.push_back(mk(3'b100, 32'h80, '0, '0, FREE, '0, 5'b11000, '0, '0, '0, '0));
        tv.push_back(mk(3'b100, 32'h80, '0, '0, ERROR, 32'h99, 5'b11100, '0, '0, 32'h80, '0));
        tv.push_back(mk(3'b100, 32'h80, '0, '0, ACCESS, 32'h88, 5'b11001, '0, '0, '0, '0));
        tv.push_back(mk(3'b100, 32'h80, '0, '0, ACCESS, 32'h8A, 5'b01101, 32'h8A, '0, 32'h80, '0));
        tv.push_back(mk(3'b000, '0, '0, '0, FREE, '0, 5'b11001, '0, '0, '0, '0));

        foreach (tv[k]) begin
            drive(tv[k].req, tv[k].iaddr, tv[k].daddr, tv[k].dstore,
                  tv[k].rs, tv[k].rload);
            @(negedge CLK);
            chk_vec($sformatf("vec%0d", k), w_outs,
                    {tv[k].flg, tv[k].eil, tv[k].edl, tv[k].ea, tv[k].es});
            @(posedge CLK);
            #1;
        end

`ifdef CACHE_MEM_CTRL_STATS_EN
        chk_w("iacc_cnt", iacc_cnt, 32'd3);
        chk_w("dacc_cnt", dacc_cnt, 32'd5);
`endif

        // Starvation: dcache writes back-to-back, icache waits.
        do_reset();
        chk_w("err_cleared", 32'(mem_err), 32'd0);
        drive(3'b101, 32'h20, 32'h10, 32'h1, ACCESS, 32'h5A5A);
        first_i = -1;
        dcnt    = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (first_i < 0 && !iwait) first_i = c;
            if (first_i < 0 && !dwait) dcnt++;
            @(posedge CLK);
            #1;
        end
        chk_w("starve_grant_cycle", 32'(first_i), 32'd9);
        chk_w("starve_d_before", 32'(dcnt), 32'd4);
        idle_in();

        // Timeout: RAM stuck BUSY during a dcache read.
        do_reset();
        drive(3'b010, '0, 32'h500, '0, BUSY, 32'h1);
        dlow = 0;
        for (int c = 0; c < 66; c++) begin
            @(negedge CLK);
            if (!dwait) dlow++;
            if (c == 64) begin
                chk_w("tmo_err_pre", 32'(mem_err), 32'd0);
                chk_w("tmo_ren_pre", 32'(ramREN), 32'd1);
            end
            if (c == 65) begin
                chk_w("tmo_err_set", 32'(mem_err), 32'd1);
                chk_w("tmo_idle", 32'(ramREN), 32'd0);
            end
            @(posedge CLK);
            #1;
        end
        chk_w("tmo_no_dwait", 32'(dlow), 32'd0);
        idle_in();

        // Reset pulsed in the middle of an icache service.
        do_reset();
        drive(3'b100, 32'h60, '0, '0, BUSY, 32'h3);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        chk_w("iserv_addr", ramaddr, 32'h60);
        #2;
        nRST = 1'b0;
        #1;
        chk_vec("async_reset", w_outs, RST_EXP);
        #1;
        nRST = 1'b1;
        idle_in();
        @(posedge CLK);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
